hdlc_host_ctrl: RTL
===================

HDLC_HOST_CTRL -- requirements
Module: hdlc_host_ctrl

Interface
REQ-001 SHALL have parameter MAX_TX_LEN, default 126, the maximum number of payload bytes per Tx frame (range 1..126).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports tx_valid (input, 1), tx_data (input, 8), tx_last (input, 1) and tx_ready (output, 1): the requester Tx byte stream; a transfer occurs when tx_valid and tx_ready are both 1.
REQ-005 SHALL have output tx_done, 1 bit: one-cycle pulse when a frame is handed off and transmission has completed.
REQ-006 SHALL have output tx_err, 1 bit: one-cycle pulse when a frame is aborted for exceeding MAX_TX_LEN.
REQ-007 SHALL have outputs rx_valid (1), rx_data (8) and rx_last (1): the received-byte stream; it has no backpressure.
REQ-008 SHALL have output Address, 3 bits: Hdlc register address.
REQ-009 SHALL have outputs WriteEnable (1), ReadEnable (1) and DataIn (8): Hdlc bus controls and write data.
REQ-010 SHALL have inputs DataOut (8), Rx_Ready (1) and Tx_Done (1): Hdlc read data and status.

Function
REQ-011 SHALL use this Hdlc register map: 0 Tx_SC (bit1 Tx_Enable, bit2 Tx_AbortFrame), 1 Tx_Buff, 3 Rx_Buff, 4 Rx_Len.
REQ-012 SHALL treat Hdlc reads as having 1-cycle latency: DataOut is sampled in the cycle after ReadEnable=1.
REQ-013 SHALL assert at most one of WriteEnable and ReadEnable in any cycle, each for exactly one cycle per access.
REQ-014 SHALL implement states IDLE, TX_LOAD, TX_START, TX_WAIT, TX_ABORT, TX_FLUSH, RX_LEN, RX_DATA.
REQ-015 SHALL arbitrate in IDLE with fixed priority: Rx_Ready=1 -> RX_LEN; else tx_valid=1 -> TX_LOAD; else stay in IDLE.
REQ-016 SHALL hold tx_ready=1 only in TX_LOAD and TX_FLUSH; it is 0 in IDLE.
REQ-017 SHALL, in TX_LOAD, write each accepted byte in the same cycle (Address=1, WriteEnable=1, DataIn=tx_data) and increment an 8-bit byte count.
REQ-018 SHALL, on an accepted byte with tx_last=1 and count (including that byte) <= MAX_TX_LEN, go to TX_START.
REQ-019 SHALL, on the (MAX_TX_LEN+1)th byte, not write that byte and go to TX_ABORT.
REQ-020 SHALL, in TX_START, write Address=0, DataIn=8'h02 for one cycle, then wait 2 cycles, then enter TX_WAIT.
REQ-021 SHALL, in TX_WAIT, pulse tx_done and return to IDLE on the first cycle with Tx_Done=1.
REQ-022 SHALL, in TX_ABORT, write Address=0, DataIn=8'h04, pulse tx_err, then enter TX_FLUSH.
REQ-023 SHALL, in TX_FLUSH, accept and discard bytes until one with tx_last=1 is accepted, then return to IDLE.
REQ-024 SHALL not preempt a Tx frame in progress: Rx_Ready is ignored outside IDLE.
REQ-025 SHALL, in RX_LEN, read Address=4 and latch the length L.
REQ-026 SHALL, if L=0, return to IDLE with no rx_valid.
REQ-027 SHALL, in RX_DATA, issue L reads of Address=3, back-to-back one per cycle.
REQ-028 SHALL present each returned byte with rx_valid=1 for one cycle, with rx_last=1 on byte L.
REQ-029 SHALL return to IDLE the cycle after the last byte is output.
REQ-030 SHALL drive Address=0 and DataIn=0 whenever no access is in progress.

Reset
REQ-031 SHALL, while Rst=0, hold the state in IDLE and drive every output to 0 (including tx_ready, rx_valid, Address and DataIn), and clear the byte count and L.
REQ-032 SHALL, when Rst is asserted mid-frame, abandon the frame with no tx_done, tx_err or further bus access.
REQ-033 SHALL leave IDLE no earlier than the first rising edge after Rst deasserts.

Verification
REQ-034 SHALL be verified with: 3-byte frame AA,55,0F -> three writes to address 1, then write 0x02 to address 0; tx_done pulses once Tx_Done=1.
REQ-035 SHALL be verified with: Rx_Ready=1 and Rx_Len=2 returning 11,22 -> reads of address 4, 3, 3; rx_valid carries 11 then 22, with rx_last on 22.
REQ-036 SHALL be verified with: Rx_Ready and tx_valid rising in the same IDLE cycle -> Rx drain completes first, then the Tx frame loads.
REQ-037 SHALL be verified with: 127-byte frame, MAX_TX_LEN=126 -> 126 writes, write 0x04 to address 0, tx_err pulse, remaining byte discarded, no tx_done.
REQ-038 SHALL be verified with: Rst=0 after the 2nd byte of a Tx frame -> all outputs 0 immediately, state IDLE, no Tx_SC write.
REQ-039 SHALL be verified with: Rx_Len=0 -> a single read of address 4, no rx_valid, return to IDLE.

Source files
------------

// File: rtl/hdlc_host_ctrl.sv
// Bridges a requester Tx byte stream and an Rx byte stream onto the Hdlc register bus.
// One transaction (Tx frame or Rx drain) runs at a time; Rx wins arbitration in IDLE.
module hdlc_host_ctrl #(
  parameter int MAX_TX_LEN = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  input  logic       Rx_Ready,
  input  logic       Tx_Done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] TX_LOAD  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_WAIT  = 3'd3;
  localparam logic [2:0] TX_ABORT = 3'd4;
  localparam logic [2:0] TX_FLUSH = 3'd5;
  localparam logic [2:0] RX_LEN   = 3'd6;
  localparam logic [2:0] RX_DATA  = 3'd7;

  localparam logic [2:0] ADDR_TX_SC   = 3'd0;
  localparam logic [2:0] ADDR_TX_BUFF = 3'd1;
  localparam logic [2:0] ADDR_RX_BUFF = 3'd3;
  localparam logic [2:0] ADDR_RX_LEN  = 3'd4;

  localparam logic [7:0] TX_ENABLE = 8'h02;
  localparam logic [7:0] TX_ABORTF = 8'h04;
  localparam logic [7:0] MAX_LEN   = 8'(MAX_TX_LEN);

  logic [2:0] state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] rx_len_q, rx_len_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_last_q, rd_last_d;
  logic       abort_last_q, abort_last_d;

  // Rx bytes come straight off DataOut in the cycle after each Rx_Buff read.
  assign rx_valid = rd_pend_q;
  assign rx_data  = rd_pend_q ? DataOut : 8'h00;
  assign rx_last  = rd_pend_q & rd_last_q;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    phase_d      = phase_q;
    rx_len_d     = rx_len_q;
    rd_cnt_d     = rd_cnt_q;
    rd_pend_d    = 1'b0;
    rd_last_d    = 1'b0;
    abort_last_d = abort_last_q;
    tx_ready     = 1'b0;
    tx_done      = 1'b0;
    tx_err       = 1'b0;
    Address      = 3'd0;
    WriteEnable  = 1'b0;
    ReadEnable   = 1'b0;
    DataIn       = 8'h00;

    case (state_q)
      IDLE: begin
        if (Rx_Ready) begin
          state_d = RX_LEN;
          phase_d = 2'd0;
        end else if (tx_valid) begin
          state_d      = TX_LOAD;
          byte_cnt_d   = 8'd0;
          abort_last_d = 1'b0;
        end
      end

      TX_LOAD: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          // The byte that would overflow the frame is dropped, never written.
          if (byte_cnt_q >= MAX_LEN) begin
            state_d      = TX_ABORT;
            abort_last_d = tx_last;
          end else begin
            Address     = ADDR_TX_BUFF;
            WriteEnable = 1'b1;
            DataIn      = tx_data;
            byte_cnt_d  = byte_cnt_q + 8'd1;
            if (tx_last) begin
              state_d = TX_START;
              phase_d = 2'd0;
            end
          end
        end
      end

      TX_START: begin
        if (phase_q == 2'd0) begin
          Address     = ADDR_TX_SC;
          WriteEnable = 1'b1;
          DataIn      = TX_ENABLE;
        end
        if (phase_q == 2'd2) begin
          state_d = TX_WAIT;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      TX_WAIT: begin
        if (Tx_Done) begin
          tx_done = 1'b1;
          state_d = IDLE;
        end
      end

      TX_ABORT: begin
        Address     = ADDR_TX_SC;
        WriteEnable = 1'b1;
        DataIn      = TX_ABORTF;
        tx_err      = 1'b1;
        state_d     = TX_FLUSH;
      end

      TX_FLUSH: begin
        // If the overflowing byte already closed the frame there is nothing left to drain.
        if (abort_last_q) begin
          state_d = IDLE;
        end else begin
          tx_ready = 1'b1;
          if (tx_valid && tx_last) begin
            state_d = IDLE;
          end
        end
      end

      RX_LEN: begin
        if (phase_q == 2'd0) begin
          Address    = ADDR_RX_LEN;
          ReadEnable = 1'b1;
          phase_d    = 2'd1;
        end else begin
          rx_len_d = DataOut;
          rd_cnt_d = 8'd0;
          state_d  = (DataOut == 8'd0) ? IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (rd_cnt_q != rx_len_q) begin
          Address    = ADDR_RX_BUFF;
          ReadEnable = 1'b1;
          rd_cnt_d   = rd_cnt_q + 8'd1;
          rd_pend_d  = 1'b1;
          rd_last_d  = ((rd_cnt_q + 8'd1) == rx_len_q);
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 8'd0;
      phase_q      <= 2'd0;
      rx_len_q     <= 8'd0;
      rd_cnt_q     <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      abort_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      phase_q      <= phase_d;
      rx_len_q     <= rx_len_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_last_q    <= rd_last_d;
      abort_last_q <= abort_last_d;
    end
  end

endmodule
